pipeline_interlock_unit: RTL and testbench

//  Sequential stall/bubble controller beside the D/X/M/W bypass logic. The bypass

---
 rtl/proc_isa_pkg.sv | 39 +++
 rtl/md_handshake_fsm.sv | 79 +++++++
 rtl/pipeline_interlock_unit.sv | 112 +++++++++++
 tb/tb_pipeline_interlock_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/proc_isa_pkg.sv
// ISA field positions, opcode/ALU-op encodings and multdiv FSM state codes
// shared by the pipeline interlock logic.
package proc_isa_pkg;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 27;
    localparam int RD_HI     = 26;
    localparam int RD_LO     = 22;
    localparam int RS_HI     = 21;
    localparam int RS_LO     = 17;
    localparam int RT_HI     = 16;
    localparam int RT_LO     = 12;
    localparam int ALUOP_HI  = 6;
    localparam int ALUOP_LO  = 2;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

endpackage

// File: rtl/md_handshake_fsm.sv
// IDLE/BUSY sequencer for the multi-cycle multdiv unit: start pulse, hold
// while busy, watchdog release and the registered overflow flag.
module md_handshake_fsm
    import proc_isa_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dxIsMd,
    input  logic       mdReady,
    input  logic       mdException,
    output logic       mdStart,
    output logic       mdHold,
    output logic       mdRelease,
    output logic       mdOvf,
    output logic [0:0] mdState
);

    localparam int WDOG_W = (MD_MAX_CYCLES > 2) ? $clog2(MD_MAX_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MD_MAX_CYCLES - 1);

    logic [0:0]        state;
    logic [0:0]        nextState;
    logic [WDOG_W-1:0] wdog;
    logic              expiry;

    // Handshake: mdStart pulses once, in IDLE, when a mul/div sits in DX with
    // valid operands; mdReady is looked at only in BUSY, and the cycle it is
    // seen high is the cycle the result is steered into XM. No backpressure.
    always_comb begin
        mdStart   = 1'b0;
        mdHold    = 1'b0;
        mdRelease = 1'b0;
        expiry    = 1'b0;
        nextState = state;
        case (state)
            MD_IDLE: begin
                if (dxIsMd) begin
                    mdStart   = 1'b1;
                    mdHold    = 1'b1;
                    nextState = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (mdReady) begin
                    mdRelease = 1'b1;
                    nextState = MD_IDLE;
                end else if (wdog == WDOG_LAST) begin
                    mdRelease = 1'b1;
                    expiry    = 1'b1;
                    nextState = MD_IDLE;
                end else begin
                    mdHold = 1'b1;
                end
            end
            default: nextState = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= MD_IDLE;
            wdog  <= '0;
            mdOvf <= 1'b0;
        end else begin
            state <= nextState;
            if (mdStart) begin
                wdog <= '0;
            end else if (state == MD_BUSY && mdHold) begin
                wdog <= wdog + WDOG_W'(1);
            end
            mdOvf <= mdRelease & ((mdReady & mdException) | expiry);
        end
    end

    assign mdState = state;

endmodule

// File: rtl/pipeline_interlock_unit.sv
// Stall/bubble controller for load-use and multi-cycle mul/div hazards.
// Optional performance counters built only when STALL_COUNTERS_EN is defined.
module pipeline_interlock_unit
    import proc_isa_pkg::*;
#(
    parameter int CNT_WIDTH     = 32,
    parameter int MD_MAX_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          in_fd,
    input  logic [31:0]          in_dx,
    input  logic                 dx_kill,
    input  logic                 md_ready,
    input  logic                 md_exception,
    output logic                 stall_pc,
    output logic                 stall_fd,
    output logic                 stall_dx,
    output logic                 bubble_dx,
    output logic                 bubble_xm,
    output logic                 md_start,
    output logic                 xm_sel_md,
    output logic                 md_ovf,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] md_ops
);

    logic [4:0] fdOp, fdRd, fdRs, fdRt, fdAlu;
    logic [4:0] dxOp, dxRd, dxAlu;
    logic       dxIsMd, dxIsLw;
    logic       fdReadsRs, fdReadsRt, fdReadsRd;
    logic       loadUse, mdBusy;
    logic       mdStart, mdHold, mdRelease, mdOvf;
    logic [0:0] mdState;
    logic       unusedBits;

    assign fdOp  = in_fd[OPCODE_HI:OPCODE_LO];
    assign fdRd  = in_fd[RD_HI:RD_LO];
    assign fdRs  = in_fd[RS_HI:RS_LO];
    assign fdRt  = in_fd[RT_HI:RT_LO];
    assign fdAlu = in_fd[ALUOP_HI:ALUOP_LO];
    assign dxOp  = in_dx[OPCODE_HI:OPCODE_LO];
    assign dxRd  = in_dx[RD_HI:RD_LO];
    assign dxAlu = in_dx[ALUOP_HI:ALUOP_LO];
    assign unusedBits = ^{in_fd[11:7], in_fd[1:0], in_dx[21:7], in_dx[1:0]};

    assign dxIsMd = (dxOp == OP_RTYPE) && ((dxAlu == ALU_MUL) || (dxAlu == ALU_DIV)) && !dx_kill;
    assign dxIsLw = (dxOp == OP_LW) && (dxRd != 5'd0) && !dx_kill;

    assign fdReadsRs = !((fdOp == OP_J) || (fdOp == OP_JAL) || (fdOp == OP_SETX));
    assign fdReadsRt = (fdOp == OP_RTYPE) && (fdAlu != ALU_SLL) && (fdAlu != ALU_SRA);
    assign fdReadsRd = (fdOp == OP_SW) || (fdOp == OP_BNE) || (fdOp == OP_BLT) || (fdOp == OP_JR);

    md_handshake_fsm #(
        .MD_MAX_CYCLES(MD_MAX_CYCLES)
    ) uMdFsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .dxIsMd     (dxIsMd),
        .mdReady    (md_ready),
        .mdException(md_exception),
        .mdStart    (mdStart),
        .mdHold     (mdHold),
        .mdRelease  (mdRelease),
        .mdOvf      (mdOvf),
        .mdState    (mdState)
    );

    assign mdBusy = (mdState == MD_BUSY);

    // dxRd != 0 is already part of dxIsLw, so r0 can never match here.
    assign loadUse = !mdBusy && !dxIsMd && dxIsLw &&
                     ((fdReadsRs && (fdRs == dxRd)) ||
                      (fdReadsRt && (fdRt == dxRd)) ||
                      (fdReadsRd && (fdRd == dxRd)));

    // Combinational controls are forced low while reset is held, so a mul/div
    // still sitting in DX cannot raise a start or stall during reset.
    assign stall_pc  = reset_n & (mdHold | loadUse);
    assign stall_fd  = reset_n & (mdHold | loadUse);
    assign stall_dx  = reset_n & mdHold;
    assign bubble_dx = reset_n & loadUse;
    assign bubble_xm = reset_n & mdHold;
    assign md_start  = reset_n & mdStart;
    assign xm_sel_md = reset_n & mdRelease;
    assign md_ovf    = mdOvf;

`ifdef STALL_COUNTERS_EN
    logic [CNT_WIDTH-1:0] stallCnt;
    logic [CNT_WIDTH-1:0] mdOpsCnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCnt <= '0;
            mdOpsCnt <= '0;
        end else begin
            if (stall_pc)  stallCnt <= stallCnt + CNT_WIDTH'(1);
            if (xm_sel_md) mdOpsCnt <= mdOpsCnt + CNT_WIDTH'(1);
        end
    end

    assign stall_cycles = stallCnt;
    assign md_ops       = mdOpsCnt;
`else
    assign stall_cycles = '0;
    assign md_ops       = '0;
`endif

    // The pipeline must never squash DX while a mul/div holds it.
    mdKillInBusy: assert property (@(posedge clock) disable iff (!reset_n) !(mdBusy && dx_kill));

endmodule

// File: tb/tb_pipeline_interlock_unit.sv
// Directed bench for pipeline_interlock_unit: one default instance and one
// with a short watchdog, both driven by the same stimulus.
module tb_pipeline_interlock_unit;
    import proc_isa_pkg::*;

    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [31:0]   in_fd, in_dx;
    logic          dx_kill, md_ready, md_exception;

    logic          sPcA, sFdA, sDxA, bDxA, bXmA, startA, selA, ovfA;
    logic          sPcB, sFdB, sDxB, bDxB, bXmB, startB, selB, ovfB;
    logic [CW-1:0] stallCntA, mdOpsA, stallCntB, mdOpsB;
    logic [7:0]    outA, outB;

    int numChecks = 0;
    int numFails  = 0;
    int expStallA = 0, expStallB = 0, expOpsA = 0, expOpsB = 0;

    always #5 clock = ~clock;

    pipeline_interlock_unit #(.CNT_WIDTH(CW), .MD_MAX_CYCLES(64)) dut (
        .clock(clock), .reset_n(reset_n), .in_fd(in_fd), .in_dx(in_dx),
        .dx_kill(dx_kill), .md_ready(md_ready), .md_exception(md_exception),
        .stall_pc(sPcA), .stall_fd(sFdA), .stall_dx(sDxA), .bubble_dx(bDxA),
        .bubble_xm(bXmA), .md_start(startA), .xm_sel_md(selA), .md_ovf(ovfA),
        .stall_cycles(stallCntA), .md_ops(mdOpsA)
    );

    pipeline_interlock_unit #(.CNT_WIDTH(CW), .MD_MAX_CYCLES(4)) dutWd (
        .clock(clock), .reset_n(reset_n), .in_fd(in_fd), .in_dx(in_dx),
        .dx_kill(dx_kill), .md_ready(md_ready), .md_exception(md_exception),
        .stall_pc(sPcB), .stall_fd(sFdB), .stall_dx(sDxB), .bubble_dx(bDxB),
        .bubble_xm(bXmB), .md_start(startB), .xm_sel_md(selB), .md_ovf(ovfB),
        .stall_cycles(stallCntB), .md_ops(mdOpsB)
    );

    // {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, md_start, xm_sel_md, md_ovf}
    assign outA = {sPcA, sFdA, sDxA, bDxA, bXmA, startA, selA, ovfA};
    assign outB = {sPcB, sFdB, sDxB, bDxB, bXmB, startB, selB, ovfB};

    function automatic logic [31:0] rInst(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, logic [4:0] alu);
        return {OP_RTYPE, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] iInst(logic [4:0] op, logic [4:0] rd, logic [4:0] rs);
        return {op, rd, rs, 17'd1};
    endfunction

    function automatic logic [31:0] cntExp(int v);
`ifdef STALL_COUNTERS_EN
        return 32'(v);
`else
        return (v == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are set at posedge+1; outputs checked 2 ns later, then one clock.
    task automatic runCycle(input string tag, input logic [7:0] expA, input logic [7:0] expB);
        #2;
        checkEq({tag, "/main"}, {24'd0, outA}, {24'd0, expA});
        checkEq({tag, "/wd"},   {24'd0, outB}, {24'd0, expB});
        if (expA[7]) expStallA++;
        if (expB[7]) expStallB++;
        if (expA[1]) expOpsA++;
        if (expB[1]) expOpsB++;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input string tag, input logic [7:0] e);
        runCycle(tag, e, e);
    endtask

    task automatic checkCounters(input string tag);
        checkEq({tag, "/stallA"}, stallCntA, cntExp(expStallA));
        checkEq({tag, "/opsA"},   mdOpsA,    cntExp(expOpsA));
        checkEq({tag, "/stallB"}, stallCntB, cntExp(expStallB));
        checkEq({tag, "/opsB"},   mdOpsB,    cntExp(expOpsB));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lwR5, lwR0, mulI, divI;
        lwR5 = iInst(OP_LW, 5'd5, 5'd1);
        lwR0 = iInst(OP_LW, 5'd0, 5'd1);
        mulI = rInst(5'd7, 5'd5, 5'd2, ALU_MUL);
        divI = rInst(5'd8, 5'd3, 5'd4, ALU_DIV);

        // Reset: a mul in DX during reset must not start or stall.
        reset_n = 1'b0; in_fd = NOP; in_dx = NOP;
        dx_kill = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
        @(posedge clock); #1;
        in_dx = mulI; in_fd = rInst(5'd6, 5'd7, 5'd2, ALU_ADD);
        #2;
        checkEq("rst/main", {24'd0, outA}, 32'd0);
        checkEq("rst/wd",   {24'd0, outB}, 32'd0);
        checkCounters("rst");
        in_dx = NOP; in_fd = NOP;
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Load-use hazards through rs, rt and rd reads, plus non-readers.
        in_dx = lwR5; in_fd = rInst(5'd6, 5'd5, 5'd2, ALU_ADD); run("lu_rs", 8'hD0);
        in_dx = NOP;                                            run("lu_after", 8'h00);
        in_dx = lwR5; in_fd = rInst(5'd6, 5'd2, 5'd5, ALU_SUB); run("lu_rt", 8'hD0);
        in_fd = rInst(5'd6, 5'd2, 5'd5, ALU_SLL);               run("lu_sll_rt", 8'h00);
        in_fd = iInst(OP_SW, 5'd5, 5'd3);                       run("lu_sw_rd", 8'hD0);
        in_fd = iInst(OP_BNE, 5'd5, 5'd3);                      run("lu_bne_rd", 8'hD0);
        in_fd = iInst(OP_J, 5'd0, 5'd5);                        run("lu_j", 8'h00);
        in_fd = iInst(OP_ADDI, 5'd5, 5'd2);                     run("lu_addi_rd", 8'h00);
        in_dx = lwR0; in_fd = rInst(5'd6, 5'd0, 5'd0, ALU_ADD); run("lu_r0", 8'h00);
        in_dx = lwR5; in_fd = rInst(5'd6, 5'd5, 5'd2, ALU_ADD); dx_kill = 1'b1;
        run("lu_kill", 8'h00);
        in_dx = mulI;                                           run("md_kill", 8'h00);
        dx_kill = 1'b0; in_dx = NOP; in_fd = NOP;
        md_ready = 1'b1;                                        run("idle_ready", 8'h00);
        md_ready = 1'b0;                                        run("idle_ready_next", 8'h00);

        // mul: ready after 3 BUSY cycles.
        in_dx = mulI; in_fd = rInst(5'd9, 5'd7, 5'd1, ALU_ADD);
        run("mul_start", 8'hEC);
        run("mul_busy1", 8'hE8);
        run("mul_busy2", 8'hE8);
        run("mul_busy3", 8'hE8);
        md_ready = 1'b1;                                        run("mul_ready", 8'h02);
        md_ready = 1'b0; in_dx = NOP;                           run("mul_xm", 8'h00);
        checkCounters("mul");

        // div with exception: md_ovf for exactly the following cycle.
        in_dx = divI;                                           run("div_start", 8'hEC);
        md_ready = 1'b1; md_exception = 1'b1;                   run("div_ready", 8'h02);
        md_ready = 1'b0; md_exception = 1'b0; in_dx = NOP;      run("div_ovf", 8'h01);
        run("div_after", 8'h00);

        // Watchdog: only the MD_MAX_CYCLES=4 instance expires.
        in_dx = mulI;                                           run("wd_start", 8'hEC);
        run("wd_busy0", 8'hE8);
        run("wd_busy1", 8'hE8);
        run("wd_busy2", 8'hE8);
        runCycle("wd_expire", 8'hE8, 8'h02);
        in_dx = NOP;                                            runCycle("wd_ovf", 8'hE8, 8'h01);
        md_ready = 1'b1;                                        runCycle("wd_mainrel", 8'h02, 8'h00);
        md_ready = 1'b0;                                        run("wd_after", 8'h00);
        checkCounters("wd");

        // Reset in the middle of BUSY, then a clean new mul.
        in_dx = mulI;                                           run("rb_start", 8'hEC);
        run("rb_busy", 8'hE8);
        reset_n = 1'b0;
        #2;
        checkEq("rb_rst/main", {24'd0, outA}, 32'd0);
        checkEq("rb_rst/wd",   {24'd0, outB}, 32'd0);
        expStallA = 0; expStallB = 0; expOpsA = 0; expOpsB = 0;
        checkCounters("rb_rst");
        in_dx = NOP;
        @(posedge clock); #1;
        reset_n = 1'b1;
        run("rb_idle", 8'h00);
        in_dx = mulI;                                           run("rb_restart", 8'hEC);
        md_ready = 1'b1;                                        run("rb_ready", 8'h02);
        md_ready = 1'b0; in_dx = NOP;                           run("rb_done", 8'h00);
        checkCounters("rb_end");

        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
        $finish;
    end

endmodule
